// File: rtl/peak_frame_streamer_if.sv
// Write-port, control and sample-stream signals of peak_frame_streamer.
// master: the side loading the RAM and requesting frames.
// slave: the streamer itself.
interface peak_frame_streamer_if #(
  parameter int VALUE_WIDTH = 32,
  parameter int INDEX_WIDTH = 11
);
  logic                   wr_en;
  logic [INDEX_WIDTH-1:0] wr_addr;
  logic [VALUE_WIDTH-1:0] wr_data;
  logic                   start;
  logic [INDEX_WIDTH-1:0] frame_len;
  logic [3:0]             gap_period;
  logic                   valid;
  logic [VALUE_WIDTH-1:0] value_o;
  logic [INDEX_WIDTH-1:0] index_o;
  logic                   last;
  logic                   busy;
  logic                   done;
  logic                   wr_err;

  modport master (
    output wr_en, wr_addr, wr_data, start, frame_len, gap_period,
    input  valid, value_o, index_o, last, busy, done, wr_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, frame_len, gap_period,
    output valid, value_o, index_o, last, busy, done, wr_err
  );
endinterface

// File: rtl/peak_frame_streamer.sv
// Frame source for the peak search: holds one frame of samples in RAM and
// replays it on start as a valid/index/last stream, with optional periodic
// idle cycles to mimic a throttled upstream. No back-pressure.
module peak_frame_streamer #(
  parameter int VALUE_WIDTH = 32,
  parameter int INDEX_WIDTH = 11,
  parameter int DEPTH       = 1024
) (
  input  logic                  clk,
  input  logic                  aresetn,
  peak_frame_streamer_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [INDEX_WIDTH-1:0] MAX_IDX = INDEX_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} state_t;

  state_t state, state_nx;

  logic [VALUE_WIDTH-1:0] mem [0:DEPTH-1];
  logic [VALUE_WIDTH-1:0] ram_q;

  logic [INDEX_WIDTH-1:0] rd_addr;
  logic [INDEX_WIDTH-1:0] last_idx;
  logic [3:0]             gap_g;
  logic [3:0]             gc;
  logic                   fin;

  logic                   start_acc;
  logic                   gap_cyc;
  logic                   beat;
  logic                   final_beat;
  logic [AW-1:0]          rd_sel;
  logic                   wr_ok;
  logic                   wr_bad;

  logic                   valid_r;
  logic                   last_r;
  logic [VALUE_WIDTH-1:0] value_r;
  logic [INDEX_WIDTH-1:0] index_r;
  logic                   wr_err_r;

  // State register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state: STREAM leaves one cycle after the final beat is issued so that
  // done appears the cycle after last, with busy still high.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_acc) state_nx = PRIME;
      PRIME:   state_nx = STREAM;
      STREAM:  if (fin) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Per-cycle decode: frame accept, gap/beat selection, RAM address, write gating.
  always_comb begin
    start_acc  = (state == IDLE) && bus.start && (bus.frame_len != '0);
    gap_cyc    = (state == STREAM) && !fin && (gap_g >= 4'd2) && (gc == gap_g - 4'd1);
    beat       = (state == STREAM) && !fin && !gap_cyc;
    final_beat = beat && (rd_addr == last_idx);
    // Prefetch the next sample on a beat so RAM data lines up with rd_addr.
    rd_sel     = rd_addr[AW-1:0] + AW'(beat);
    wr_ok      = bus.wr_en && (state == IDLE) && (bus.wr_addr <= MAX_IDX);
    wr_bad     = bus.wr_en && !wr_ok;
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.valid   = valid_r;
  assign bus.last    = last_r;
  assign bus.value_o = value_r;
  assign bus.index_o = index_r;
  assign bus.wr_err  = wr_err_r;

  // Frame sequencing: length/gap latch, gap counter, read pointer, final-beat flag.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rd_addr  <= '0;
      last_idx <= '0;
      gap_g    <= '0;
      gc       <= '0;
      fin      <= 1'b0;
    end else if (start_acc) begin
      last_idx <= (bus.frame_len > MAX_IDX) ? MAX_IDX : bus.frame_len - 1'b1;
      gap_g    <= bus.gap_period;
      gc       <= '0;
      rd_addr  <= '0;
      fin      <= 1'b0;
    end else if ((state == STREAM) && !fin) begin
      if (gap_g >= 4'd2) gc <= (gc == gap_g - 4'd1) ? '0 : gc + 4'd1;
      if (beat) rd_addr <= rd_addr + 1'b1;
      fin <= final_beat;
    end
  end

  // Registered stream outputs and write-error pulse; data/index hold on idle cycles.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      valid_r  <= 1'b0;
      last_r   <= 1'b0;
      value_r  <= '0;
      index_r  <= '0;
      wr_err_r <= 1'b0;
    end else begin
      valid_r  <= beat;
      last_r   <= final_beat;
      wr_err_r <= wr_bad;
      if (beat) begin
        value_r <= ram_q;
        index_r <= rd_addr;
      end
    end
  end

  // Frame RAM: write port plus registered read (contents are not reset).
  always_ff @(posedge clk) begin
    if (wr_ok) mem[bus.wr_addr[AW-1:0]] <= bus.wr_data;
    ram_q <= mem[rd_sel];
  end

endmodule

// File: tb/tb_peak_frame_streamer.sv
// Directed bench for peak_frame_streamer: RAM holds i*3, frames are replayed
// and every visible cycle is compared against hand-derived expectations.
module tb_peak_frame_streamer;
  localparam int VW    = 32;
  localparam int IW    = 11;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  peak_frame_streamer_if #(.VALUE_WIDTH(VW), .INDEX_WIDTH(IW)) bus ();

  peak_frame_streamer #(.VALUE_WIDTH(VW), .INDEX_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete frame: idle cycle c (1-based stream cycle) when g>=2 and c%g==0.
  task automatic run_frame(input int n_req, input int g, input int inject_at);
    int n, beats, c, inj_c;
    n = (n_req > DEPTH) ? DEPTH : n_req;
    bus.frame_len  = IW'(n_req);
    bus.gap_period = 4'(g);
    bus.start      = 1'b1;
    tick;
    bus.start = 1'b0;
    chk("prime_busy", bus.busy, 1);
    chk("prime_valid", bus.valid, 0);
    tick;
    chk("latency_valid", bus.valid, 0);
    beats = 0;
    c     = 0;
    inj_c = -10;
    while (beats < n && c < 4 * DEPTH) begin
      tick;
      c++;
      if (c == inj_c + 1) begin
        chk("wr_err_pulse", bus.wr_err, 1);
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
      end
      if (c == inj_c + 2) chk("wr_err_clear", bus.wr_err, 0);
      if (g >= 2 && (c % g) == 0) begin
        chk("gap_valid", bus.valid, 0);
        chk("gap_last", bus.last, 0);
        chk("gap_index_hold", bus.index_o, beats - 1);
      end else begin
        chk("beat_valid", bus.valid, 1);
        chk("beat_index", bus.index_o, beats);
        chk("beat_value", bus.value_o, 3 * beats);
        chk("beat_last", bus.last, beats == n - 1);
        beats++;
        if (inject_at >= 0 && beats == inject_at && inj_c < 0) begin
          bus.start     = 1'b1;
          bus.frame_len = IW'(4);
          bus.wr_en     = 1'b1;
          bus.wr_addr   = IW'(5);
          bus.wr_data   = 32'hDEAD_BEEF;
          inj_c         = c;
        end
      end
    end
    chk("beat_count", beats, n);
    chk("stream_cycles", c, (g >= 2) ? n + (n + g - 2) / (g - 1) - 1 : n);
    tick;
    chk("done_pulse", bus.done, 1);
    chk("done_busy", bus.busy, 1);
    chk("done_valid", bus.valid, 0);
    chk("done_last", bus.last, 0);
    tick;
    chk("done_clear", bus.done, 0);
    chk("idle_busy", bus.busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.frame_len = '0; bus.gap_period = '0;

    // Reset state.
    tick; tick;
    chk("rst_valid", bus.valid, 0);
    chk("rst_last", bus.last, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_wr_err", bus.wr_err, 0);
    chk("rst_index", bus.index_o, 0);
    chk("rst_value", bus.value_o, 0);
    aresetn = 1'b1;
    tick;

    // Load RAM[i] = 3*i.
    for (int i = 0; i < DEPTH; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = IW'(i);
      bus.wr_data = VW'(3 * i);
      tick;
      if (i == 1) chk("load_no_err", bus.wr_err, 0);
    end
    bus.wr_en = 1'b0;

    // Write and start in the same IDLE cycle: frame sees the new word.
    bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_data = 32'h77;
    bus.frame_len = IW'(2); bus.gap_period = '0; bus.start = 1'b1;
    tick;
    bus.wr_en = 1'b0; bus.start = 1'b0;
    chk("ws_no_err", bus.wr_err, 0);
    tick; tick;
    chk("ws_valid", bus.valid, 1);
    chk("ws_value_new", bus.value_o, 32'h77);
    tick;
    chk("ws_last", bus.last, 1);
    chk("ws_index", bus.index_o, 1);
    chk("ws_value1", bus.value_o, 3);
    tick;
    chk("ws_done", bus.done, 1);
    tick;
    chk("ws_idle", bus.busy, 0);
    bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_data = '0;
    tick;
    bus.wr_en = 1'b0;

    // Plain frame, then gapped frames.
    run_frame(16, 0, -1);
    run_frame(14, 7, -1);
    run_frame(5, 3, -1);
    run_frame(6, 1, -1);

    // Zero-length start is ignored.
    bus.frame_len = '0; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("len0_busy", bus.busy, 0);
      chk("len0_valid", bus.valid, 0);
    end

    // Out-of-range write is dropped (RAM[476] verified by the full frame).
    bus.wr_en = 1'b1; bus.wr_addr = IW'(1500); bus.wr_data = 32'h5555_5555;
    tick;
    bus.wr_en = 1'b0;
    chk("oor_wr_err", bus.wr_err, 1);
    tick;
    chk("oor_wr_err_clear", bus.wr_err, 0);

    // Oversize length clamps to DEPTH.
    run_frame(2000, 0, -1);

    // Start and write while busy are ignored; RAM[5] still 15 afterwards.
    run_frame(16, 0, 3);
    run_frame(8, 0, -1);

    // Asynchronous abort at beat 8 of a 32-sample frame.
    bus.frame_len = IW'(32); bus.gap_period = '0; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    tick;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("abort_pre_index", bus.index_o, i);
    end
    tick;
    chk("abort_beat8", bus.index_o, 8);
    #2 aresetn = 1'b0;
    #1;
    chk("abort_valid", bus.valid, 0);
    chk("abort_index", bus.index_o, 0);
    chk("abort_value", bus.value_o, 0);
    chk("abort_last", bus.last, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    tick; tick;
    aresetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("abort_no_done", bus.done, 0);
      chk("abort_no_valid", bus.valid, 0);
    end
    run_frame(32, 0, -1);

    // start held high: 8-cycle frame period (PRIME, lat, 4 beats, DONE, IDLE).
    bus.frame_len = IW'(4); bus.gap_period = '0; bus.start = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick;
      p = k % 8;
      chk("b2b_busy", bus.busy, p != 7);
      chk("b2b_valid", bus.valid, (p >= 2) && (p <= 5));
      chk("b2b_done", bus.done, p == 6);
      chk("b2b_last", bus.last, p == 5);
      if (p >= 2 && p <= 5) chk("b2b_index", bus.index_o, p - 2);
      if (k == 15) bus.start = 1'b0;
    end
    tick;
    chk("b2b_stop", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
